// File: rtl/mem_axi_master_pkg.sv
// Shared types and constants for the mem_axi_master block.
//   state_e          : controller states
//   Resp*            : AXI response codes
//   DefaultToCycles  : default watchdog limit
//   access_ok()      : alignment rule used when MEM_AXI_ALIGN_CHECK_EN is defined
//   resp_is_err()    : maps an AXI response code to the core error flag
package mem_axi_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StRdata,
        StWaddr,
        StWresp,
        StResp
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    localparam int unsigned DefaultToCycles = 1023;

    // Loads must be word aligned; stores must use a byte-lane pattern that is
    // naturally aligned to the byte address.
    function automatic logic access_ok(logic we, logic [1:0] a, logic [3:0] strb);
        if (!we) begin
            return a == 2'b00;
        end
        case (strb)
            4'b1111: return a == 2'b00;
            4'b0011: return a == 2'b00;
            4'b1100: return a == 2'b10;
            4'b0001: return a == 2'b00;
            4'b0010: return a == 2'b01;
            4'b0100: return a == 2'b10;
            4'b1000: return a == 2'b11;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic resp_is_err(logic [1:0] resp);
        return (resp == RespSlverr) || (resp == RespDecerr);
    endfunction

endpackage

// File: rtl/mem_axi_master_if.sv
// AXI-lite style single-beat master bus used by mem_axi_master.
//   modport master : drives AR/AW/W valids, addresses, data and R/B readies
//   modport slave  : the opposite directions
interface mem_axi_master_if;

    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    modport master (
        output m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

endinterface

// File: rtl/mem_axi_master.sv
// Bridges a simple core load/store request port onto a single-beat AXI master.
// One transaction outstanding; a sticky watchdog flags any AXI wait that lasts
// TO_CYCLES cycles without aborting the transfer.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only while idle)
//   req_we/addr/wdata/strb   : request payload, latched on acceptance
//   resp_valid/rdata/err     : one-cycle response pulse
//   timeout                  : sticky watchdog flag
//   m_axi                    : AXI master modport
// Optional feature: define MEM_AXI_ALIGN_CHECK_EN to reject misaligned accesses
// locally with resp_err=1 and no AXI traffic.
module mem_axi_master
    import mem_axi_master_pkg::*;
#(
    parameter int unsigned TO_CYCLES = DefaultToCycles
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [3:0]              req_strb,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic                    timeout,
    mem_axi_master_if.master        m_axi
);

    localparam logic [31:0] ToLast = 32'(TO_CYCLES) - 32'd1;

    state_e      state_q;
    logic        req_ready_q, resp_valid_q, resp_err_q, timeout_q;
    logic [31:0] resp_rdata_q, addr_q, wdata_q, cnt_q;
    logic [3:0]  strb_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic        aw_done, w_done;

    // A write channel counts as done once its valid has dropped or it handshakes now.
    assign aw_done = !awvalid_q || m_axi.m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi.m_axi_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            timeout_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            cnt_q        <= '0;
        end else begin
            // Saturating wait counter; every state change below overrides it to zero.
            if (cnt_q != 32'(TO_CYCLES)) begin
                cnt_q <= cnt_q + 32'd1;
            end
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        strb_q      <= req_strb;
                        cnt_q       <= '0;
`ifdef MEM_AXI_ALIGN_CHECK_EN
                        if (!access_ok(req_we, req_addr[1:0], req_strb)) begin
                            // resp_valid rises on the following cycle in StResp.
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= StResp;
                        end else
`endif
                        if (req_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWaddr;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRaddr;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                StRaddr: begin
                    if (m_axi.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdata;
                        cnt_q     <= '0;
                    end else if (cnt_q == ToLast) begin
                        timeout_q <= 1'b1;
                    end
                end
                StRdata: begin
                    if (m_axi.m_axi_rvalid) begin
                        rready_q     <= 1'b0;
                        resp_rdata_q <= m_axi.m_axi_rdata;
                        resp_err_q   <= resp_is_err(m_axi.m_axi_rresp);
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                        cnt_q        <= '0;
                    end else if (cnt_q == ToLast) begin
                        timeout_q <= 1'b1;
                    end
                end
                StWaddr: begin
                    if (m_axi.m_axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_axi.m_axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= StWresp;
                        cnt_q    <= '0;
                    end else if (cnt_q == ToLast) begin
                        timeout_q <= 1'b1;
                    end
                end
                StWresp: begin
                    if (m_axi.m_axi_bvalid) begin
                        bready_q     <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= resp_is_err(m_axi.m_axi_bresp);
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                        cnt_q        <= '0;
                    end else if (cnt_q == ToLast) begin
                        timeout_q <= 1'b1;
                    end
                end
                StResp: begin
                    // Entered with resp_valid low only from the local alignment reject.
                    if (resp_valid_q) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= StIdle;
                        cnt_q        <= '0;
                    end else begin
                        resp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign req_ready           = req_ready_q;
    assign resp_valid          = resp_valid_q;
    assign resp_rdata          = resp_rdata_q;
    assign resp_err            = resp_err_q;
    assign timeout             = timeout_q;
    assign m_axi.m_axi_araddr  = addr_q;
    assign m_axi.m_axi_arvalid = arvalid_q;
    assign m_axi.m_axi_rready  = rready_q;
    assign m_axi.m_axi_awaddr  = addr_q;
    assign m_axi.m_axi_awvalid = awvalid_q;
    assign m_axi.m_axi_wdata   = wdata_q;
    assign m_axi.m_axi_wstrb   = strb_q;
    assign m_axi.m_axi_wvalid  = wvalid_q;
    assign m_axi.m_axi_bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_master.sv
// Self-checking bench for mem_axi_master: a delay-programmable AXI slave,
// directed scenarios and randomized loads/stores against a transaction model.
module tb_mem_axi_master;
    import mem_axi_master_pkg::*;

    localparam int unsigned ToCyc = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        req_ready, resp_valid, resp_err, timeout;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    mem_axi_master_if axi ();

    mem_axi_master #(.TO_CYCLES(ToCyc)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .timeout    (timeout),
        .m_axi      (axi)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, cyc = 0, aw_cyc = 0, w_cyc = 0;
    int          resp_pulses = 0, proto_err = 0;
    bit          rd_pend = 0, aw_got = 0, w_got = 0;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rd_pend = 0;
            aw_got  = 0;
            w_got   = 0;
        end else begin
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
                cap_araddr = axi.m_axi_araddr;
                ar_hs++;
                rd_pend = 1;
            end
            if (axi.m_axi_rvalid && axi.m_axi_rready) rd_pend = 0;
            if (axi.m_axi_awvalid && axi.m_axi_awready) begin
                cap_awaddr = axi.m_axi_awaddr;
                aw_hs++;
                aw_got = 1;
                aw_cyc = cyc;
            end
            if (axi.m_axi_wvalid && axi.m_axi_wready) begin
                cap_wdata = axi.m_axi_wdata;
                cap_wstrb = axi.m_axi_wstrb;
                w_hs++;
                w_got = 1;
                w_cyc = cyc;
            end
            if (axi.m_axi_bvalid && axi.m_axi_bready) begin
                aw_got = 0;
                w_got  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            axi.m_axi_arready = 0; axi.m_axi_rvalid = 0; axi.m_axi_awready = 0;
            axi.m_axi_wready = 0;  axi.m_axi_bvalid = 0;
            axi.m_axi_rdata = '0;  axi.m_axi_rresp = '0; axi.m_axi_bresp = '0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (axi.m_axi_arvalid) begin
                axi.m_axi_arready = (ar_cnt >= ar_dly); ar_cnt++;
            end else begin
                axi.m_axi_arready = 0; ar_cnt = 0;
            end
            if (axi.m_axi_awvalid) begin
                axi.m_axi_awready = (aw_cnt >= aw_dly); aw_cnt++;
            end else begin
                axi.m_axi_awready = 0; aw_cnt = 0;
            end
            if (axi.m_axi_wvalid) begin
                axi.m_axi_wready = (w_cnt >= w_dly); w_cnt++;
            end else begin
                axi.m_axi_wready = 0; w_cnt = 0;
            end
            if (rd_pend) begin
                axi.m_axi_rvalid = (r_cnt >= r_dly); r_cnt++;
                axi.m_axi_rdata = s_rdata;
                axi.m_axi_rresp = s_rresp;
            end else begin
                axi.m_axi_rvalid = 0; r_cnt = 0;
            end
            if (aw_got && w_got) begin
                axi.m_axi_bvalid = (b_cnt >= b_dly); b_cnt++;
                axi.m_axi_bresp = s_bresp;
            end else begin
                axi.m_axi_bvalid = 0; b_cnt = 0;
            end
            if (axi.m_axi_bready && !(aw_got && w_got)) proto_err++;
            if (resp_valid) resp_pulses++;
        end
    end

    // ---------------- reference model ----------------
    function automatic bit model_reject(bit we, logic [31:0] a, logic [3:0] s);
`ifdef MEM_AXI_ALIGN_CHECK_EN
        int unsigned sv, n, lo;
        if (!we) return a[1:0] != 2'b00;
        sv = s;
        n  = $countones(s);
        if (n == 0) return 1;
        lo = 0;
        while (((sv >> lo) & 1) == 0) lo++;
        // Lanes must be one contiguous, naturally aligned 1/2/4-byte block at the address.
        if ((sv >> lo) != ((1 << n) - 1)) return 1;
        if (n != 1 && n != 2 && n != 4) return 1;
        if (lo != a[1:0]) return 1;
        return (a[1:0] % n) != 0;
`else
        return 0;
`endif
    endfunction

    function automatic bit model_err(logic [1:0] r);
        return r == 2'b10 || r == 2'b11;
    endfunction

    // ---------------- drivers ----------------
    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        bit ok = 0;
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_strb = s;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else check_eq("accept_bound", 0, 1);
        #1 req_valid = 0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 200);
        if (!resp_valid) check_eq("resp_bound", 0, 1);
    endtask

    task automatic run_txn(input string tag, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input bit chk_lat);
        int lat, ar0, aw0, w0, exp_lat;
        bit rej;
        ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
        rej = model_reject(we, a, s);
        issue(we, a, d, s);
        wait_resp(lat);
        if (rej) begin
            exp_lat = 2;
            check_eq({tag, "_err"}, resp_err, 1);
            check_eq({tag, "_rdata"}, resp_rdata, 0);
            check_eq({tag, "_no_axi"}, ar_hs + aw_hs + w_hs, ar0 + aw0 + w0);
        end else if (!we) begin
            exp_lat = 3 + ar_dly + r_dly;
            check_eq({tag, "_araddr"}, cap_araddr, a);
            check_eq({tag, "_ar_once"}, ar_hs, ar0 + 1);
            check_eq({tag, "_rdata"}, resp_rdata, s_rdata);
            check_eq({tag, "_err"}, resp_err, model_err(s_rresp));
        end else begin
            exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            check_eq({tag, "_awaddr"}, cap_awaddr, a);
            check_eq({tag, "_wdata"}, cap_wdata, d);
            check_eq({tag, "_wstrb"}, cap_wstrb, s);
            check_eq({tag, "_rdata"}, resp_rdata, 0);
            check_eq({tag, "_err"}, resp_err, model_err(s_bresp));
        end
        if (chk_lat) check_eq({tag, "_lat"}, lat, exp_lat);
        @(negedge clk);
        check_eq({tag, "_pulse"}, resp_valid, 0);
        check_eq({tag, "_ready_after"}, req_ready, 1);
    endtask

    task automatic set_dly(input int ar, input int r, input int aw, input int w, input int b);
        ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_ctl"}, {23'd0, req_ready, resp_valid, resp_err, timeout,
                 axi.m_axi_arvalid, axi.m_axi_rready, axi.m_axi_awvalid,
                 axi.m_axi_wvalid, axi.m_axi_bready}, 0);
        check_eq({tag, "_araddr"}, axi.m_axi_araddr, 0);
        check_eq({tag, "_wdata"}, axi.m_axi_wdata, 0);
        check_eq({tag, "_rdata"}, resp_rdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int p0, lat;
        logic [3:0] strbs [8];
        strbs = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
        rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
        set_dly(0, 0, 0, 0, 0);
        s_rdata = '0; s_rresp = RespOkay; s_bresp = RespOkay;
        repeat (3) @(posedge clk);
        #1 check_reset_outs("reset");
        @(negedge clk) rst = 0;

        // Zero-wait load.
        s_rdata = 32'hDEADBEEF;
        run_txn("load0", 0, 32'h0000_1040, 0, 4'hF, 1);

        // Store with W accepted 4 cycles before AW.
        set_dly(0, 0, 4, 0, 0);
        p0 = resp_pulses;
        run_txn("store0", 1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1);
        check_eq("store0_w_first", aw_cyc - w_cyc, 4);
        check_eq("store0_one_pulse", resp_pulses - p0, 1);

        // Error responses.
        set_dly(0, 1, 0, 0, 2);
        s_rresp = RespSlverr; s_rdata = 32'hCAFE_0001;
        run_txn("load_slverr", 0, 32'h0000_3000, 0, 4'hF, 1);
        s_bresp = RespDecerr;
        run_txn("store_decerr", 1, 32'h0000_3004, 32'hA5A5_5A5A, 4'hF, 1);
        s_rresp = RespOkay; s_bresp = RespOkay;

        // Misaligned load: rejected locally only when the alignment check is built in.
        set_dly(0, 0, 0, 0, 0);
        run_txn("load_misalign", 0, 32'h0000_1042, 0, 4'hF, 1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            bit we;
            logic [31:0] a;
            we = $urandom_range(0, 1);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            set_dly($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 4));
            s_rdata = $urandom;
            s_rresp = 2'($urandom_range(0, 3));
            s_bresp = 2'($urandom_range(0, 3));
            run_txn("rand", we, a, $urandom, strbs[$urandom_range(0, 7)], 1);
        end
        check_eq("no_bready_early", proto_err, 0);
        check_eq("no_timeout_yet", timeout, 0);

        // Watchdog: AR stalls 20 cycles with an 8-cycle limit.
        set_dly(20, 0, 0, 0, 0);
        s_rdata = 32'h0BAD_F00D; s_rresp = RespOkay;
        issue(0, 32'h0000_4000, 0, 4'hF);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) check_eq("wd_before", timeout, 0);
            if (k == 9) begin
                check_eq("wd_set", timeout, 1);
                check_eq("wd_arvalid", axi.m_axi_arvalid, 1);
            end
        end
        wait_resp(lat);
        check_eq("wd_lat", lat + 9, 23);
        check_eq("wd_rdata", resp_rdata, 32'h0BAD_F00D);
        check_eq("wd_err", resp_err, 0);
        check_eq("wd_sticky", timeout, 1);

        // Reset while waiting in the read-data phase.
        set_dly(0, 10, 0, 0, 0);
        issue(0, 32'h0000_5000, 0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_rdata", axi.m_axi_rready, 1);
        p0 = resp_pulses;
        rst = 1;
        @(posedge clk);
        #1 check_reset_outs("midrst");
        @(negedge clk) rst = 0;
        repeat (15) @(negedge clk);
        check_eq("midrst_no_pulse", resp_pulses, p0);
        set_dly(0, 0, 0, 0, 0);
        s_rdata = 32'h7777_1234;
        run_txn("after_rst", 0, 32'h0000_6000, 0, 4'hF, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
